// File: rtl/execute.sv
// Execute stage: single-cycle ALU plus an iterative radix-2 multiply/divide unit,
// followed by the EXE->MEM pipeline register.
module execute (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EXE_V,
  input  logic [63:0] EXE_NPC,
  input  logic [31:0] EXE_IR,
  input  logic [63:0] EXE_A,
  input  logic [63:0] EXE_B,
  input  logic [63:0] EXE_SR1,
  input  logic [63:0] EXE_SR2,
  input  logic [4:0]  EXE_ALU_OP,
  input  logic        EXE_W,
  input  logic [63:0] EXE_RFD,
  input  logic [63:0] EXE_DRID,
  input  logic [63:0] EXE_CSRFD,
  input  logic        EXE_FLUSH,
  input  logic        MEM_STALL,
  output logic        EXE_STALL,
  output logic [63:0] MEM_NPC,
  output logic [63:0] MEM_ALU_RESULT,
  output logic [63:0] MEM_SR1,
  output logic [63:0] MEM_SR2,
  output logic [63:0] MEM_RFD,
  output logic [63:0] MEM_DRID,
  output logic [63:0] MEM_CSRFD,
  output logic [31:0] MEM_IR,
  output logic        MEM_V
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_REM    = 5'd22;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e       r_state;
  state_e       w_next;
  logic         w_start;
  logic [5:0]   w_shamt;
  logic [63:0]  w_res64;
  logic [31:0]  w_res32;
  logic [63:0]  w_alu_res;
  logic         w_is_m;
  logic         w_is_div;
  logic         w_sgn_a;
  logic         w_sgn_b;
  logic [63:0]  w_a_ext;
  logic [63:0]  w_b_ext;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [63:0]  w_a_mag;
  logic [63:0]  w_b_mag;

  logic [63:0]  r_hi;
  logic [63:0]  r_lo;
  logic [63:0]  r_b;
  logic [5:0]   r_cnt;
  logic [2:0]   r_op;
  logic         r_w;
  logic         r_qneg;
  logic         r_rneg;

  logic [64:0]  w_mul_sum;
  logic [64:0]  w_div_sh;
  logic         w_div_ge;
  logic [63:0]  w_div_hi;
  logic [127:0] w_prod;
  logic [127:0] w_prod_s;
  logic [63:0]  w_quo;
  logic [63:0]  w_quo_s;
  logic [63:0]  w_rem_s;
  logic [63:0]  w_m64;
  logic [63:0]  w_m_res;
  logic [63:0]  w_result;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_shamt = EXE_W ? {1'b0, EXE_B[4:0]} : EXE_B[5:0];
    w_res64 = '0;
    w_res32 = '0;
    case (EXE_ALU_OP)
      OP_ADD:   begin w_res64 = EXE_A + EXE_B;  w_res32 = EXE_A[31:0] + EXE_B[31:0]; end
      OP_SUB:   begin w_res64 = EXE_A - EXE_B;  w_res32 = EXE_A[31:0] - EXE_B[31:0]; end
      OP_SLL:   begin w_res64 = EXE_A << w_shamt; w_res32 = EXE_A[31:0] << w_shamt[4:0]; end
      OP_SLT:   begin
        w_res64 = {63'd0, $signed(EXE_A) < $signed(EXE_B)};
        w_res32 = {31'd0, $signed(EXE_A[31:0]) < $signed(EXE_B[31:0])};
      end
      OP_SLTU:  begin
        w_res64 = {63'd0, EXE_A < EXE_B};
        w_res32 = {31'd0, EXE_A[31:0] < EXE_B[31:0]};
      end
      OP_XOR:   begin w_res64 = EXE_A ^ EXE_B;  w_res32 = EXE_A[31:0] ^ EXE_B[31:0]; end
      OP_SRL:   begin w_res64 = EXE_A >> w_shamt; w_res32 = EXE_A[31:0] >> w_shamt[4:0]; end
      OP_SRA:   begin
        w_res64 = $signed(EXE_A) >>> w_shamt;
        w_res32 = $signed(EXE_A[31:0]) >>> w_shamt[4:0];
      end
      OP_OR:    begin w_res64 = EXE_A | EXE_B;  w_res32 = EXE_A[31:0] | EXE_B[31:0]; end
      OP_AND:   begin w_res64 = EXE_A & EXE_B;  w_res32 = EXE_A[31:0] & EXE_B[31:0]; end
      OP_PASSB: begin w_res64 = EXE_B;          w_res32 = EXE_B[31:0]; end
      default:  begin w_res64 = '0;             w_res32 = '0; end
    endcase
    w_alu_res = EXE_W ? {{32{w_res32[31]}}, w_res32} : w_res64;
  end

  // Operand conditioning for the M unit: extend to the working width, then take magnitudes.
  always_comb begin
    w_is_m   = (EXE_ALU_OP[4:3] == 2'b10);
    w_is_div = EXE_ALU_OP[2];
    w_sgn_a  = (EXE_ALU_OP inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    w_sgn_b  = (EXE_ALU_OP inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    w_a_ext  = EXE_W ? {{32{w_sgn_a & EXE_A[31]}}, EXE_A[31:0]} : EXE_A;
    w_b_ext  = EXE_W ? {{32{w_sgn_b & EXE_B[31]}}, EXE_B[31:0]} : EXE_B;
    w_a_neg  = w_sgn_a & w_a_ext[63];
    w_b_neg  = w_sgn_b & w_b_ext[63];
    w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    EXE_STALL = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (EXE_V && w_is_m) begin
          EXE_STALL = 1'b1;
          if (!EXE_FLUSH) begin
            w_next  = S_RUN;
            w_start = 1'b1;
          end
        end
      end
      S_RUN: begin
        EXE_STALL = 1'b1;
        if (EXE_FLUSH)          w_next = S_IDLE;
        else if (r_cnt == 6'd0) w_next = S_DONE;
      end
      S_DONE: begin
        EXE_STALL = MEM_STALL;
        if (EXE_FLUSH || !MEM_STALL) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (RESET) EXE_STALL = 1'b0;
  end

  // One radix-2 step per RUN cycle: shift-add multiply or restoring divide.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 65'd0);
    w_div_sh  = {r_hi, r_lo[63]};
    w_div_ge  = (w_div_sh >= {1'b0, r_b});
    w_div_hi  = w_div_ge ? (w_div_sh[63:0] - r_b) : w_div_sh[63:0];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_op   <= '0;
      r_w    <= 1'b0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (w_start) begin
      r_cnt  <= EXE_W ? 6'd31 : 6'd63;
      r_op   <= EXE_ALU_OP[2:0];
      r_w    <= EXE_W;
      r_b    <= w_b_mag;
      r_hi   <= '0;
      // A 32-bit dividend sits in the top half so its MSB is shifted out first.
      r_lo   <= (EXE_W && w_is_div) ? {w_a_mag[31:0], 32'd0} : w_a_mag;
      // Divide by zero keeps an all-ones quotient regardless of dividend sign.
      r_qneg <= (w_a_neg ^ w_b_neg) & ~(w_is_div & (w_b_mag == 64'd0));
      r_rneg <= w_a_neg;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - 6'd1;
      if (r_op[2]) begin
        r_hi <= w_div_hi;
        r_lo <= {r_lo[62:0], w_div_ge};
      end else begin
        r_hi <= w_mul_sum[64:1];
        r_lo <= {w_mul_sum[0], r_lo[63:1]};
      end
    end
  end

  always_comb begin
    w_prod   = r_w ? {64'd0, r_hi[31:0], r_lo[63:32]} : {r_hi, r_lo};
    w_prod_s = r_qneg ? -w_prod : w_prod;
    w_quo    = r_w ? {32'd0, r_lo[31:0]} : r_lo;
    w_quo_s  = r_qneg ? -w_quo : w_quo;
    w_rem_s  = r_rneg ? -r_hi : r_hi;
    case (r_op)
      3'd0:          w_m64 = w_prod_s[63:0];
      3'd1, 3'd2,
      3'd3:          w_m64 = r_w ? {32'd0, w_prod_s[63:32]} : w_prod_s[127:64];
      3'd4, 3'd5:    w_m64 = w_quo_s;
      default:       w_m64 = w_rem_s;
    endcase
    w_m_res  = r_w ? {{32{w_m64[31]}}, w_m64[31:0]} : w_m64;
    w_result = (r_state == S_DONE) ? w_m_res : w_alu_res;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MEM_V          <= 1'b0;
      MEM_NPC        <= '0;
      MEM_IR         <= '0;
      MEM_ALU_RESULT <= '0;
      MEM_SR1        <= '0;
      MEM_SR2        <= '0;
      MEM_RFD        <= '0;
      MEM_DRID       <= '0;
      MEM_CSRFD      <= '0;
    end else if (!MEM_STALL) begin
      if (EXE_STALL) begin
        MEM_V <= 1'b0;
      end else begin
        MEM_V          <= EXE_V & ~EXE_FLUSH;
        MEM_NPC        <= EXE_NPC;
        MEM_IR         <= EXE_IR;
        MEM_ALU_RESULT <= w_result;
        MEM_SR1        <= EXE_SR1;
        MEM_SR2        <= EXE_SR2;
        MEM_RFD        <= EXE_RFD;
        MEM_DRID       <= EXE_DRID;
        MEM_CSRFD      <= EXE_CSRFD;
      end
    end
  end

endmodule
